// File: rtl/rte_pkg.sv
// rte_pkg: shared header-field positions, port indices and arbiter types for rte_switch.
// Round-robin arbitration is built only when the macro RTE_RR_EN is defined.
package rte_pkg;

    localparam int CWI     = 0;
    localparam int CCWI    = 1;
    localparam int PEI     = 2;
    localparam int N_PORTS = 3;

    typedef enum logic {
        ARB_A = 1'b0,
        ARB_B = 1'b1
    } arb_sel_e;

    function automatic int dir_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int hop_msb(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int hop_lsb(input int data_w, input int hop_w);
        return data_w - 1 - hop_w;
    endfunction

endpackage

// File: rtl/rte_arb2.sv
// rte_arb2: two-requester arbiter gated by the output stage's ability to load.
// Requester A is the favoured side; with RTE_RR_EN a 1-bit pointer alternates on contention.
module rte_arb2
    import rte_pkg::*;
(
`ifdef RTE_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic can_load_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    arb_sel_e pick_s;

`ifdef RTE_RR_EN
    arb_sel_e ptr_q;
    arb_sel_e ptr_d;

    // Pointer flips only on a cycle where both contended and a grant was issued.
    always_comb begin
        ptr_d = ptr_q;
        if (req_a_i && req_b_i && can_load_i) begin
            ptr_d = (ptr_q == ARB_A) ? ARB_B : ARB_A;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ARB_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_s = ptr_q;
`else
    assign pick_s = ARB_A;
`endif

    // Grant decode: nothing is granted unless the stage can take a packet.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (!can_load_i) begin
            gnt_a_o = 1'b0;
            gnt_b_o = 1'b0;
        end else if (req_a_i && req_b_i) begin
            gnt_a_o = (pick_s == ARB_A);
            gnt_b_o = (pick_s == ARB_B);
        end else begin
            gnt_a_o = req_a_i;
            gnt_b_o = req_b_i;
        end
    end

endmodule

// File: rtl/rte_switch.sv
// rte_switch: 3-in/3-out ring-node switch with hop-based routing and registered outputs.
// Define RTE_RR_EN for round-robin arbitration; otherwise ring inputs and cwi have fixed priority.
module rte_switch
    import rte_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int HOP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cwi_v,
    input  logic              ccwi_v,
    input  logic              pei_v,
    input  logic [DATA_W-1:0] cwi_d,
    input  logic [DATA_W-1:0] ccwi_d,
    input  logic [DATA_W-1:0] pei_d,
    output logic              cwi_rdy,
    output logic              ccwi_rdy,
    output logic              pei_rdy,
    output logic              cwo_v,
    output logic              ccwo_v,
    output logic              peo_v,
    output logic [DATA_W-1:0] cwo_d,
    output logic [DATA_W-1:0] ccwo_d,
    output logic [DATA_W-1:0] peo_d,
    input  logic              cwo_rdy,
    input  logic              ccwo_rdy,
    input  logic              peo_rdy
);

    localparam int DIR_B = dir_bit(DATA_W);
    localparam int HOP_M = hop_msb(DATA_W);
    localparam int HOP_L = hop_lsb(DATA_W, HOP_W);

    logic [HOP_W-1:0]   cwi_hop_s;
    logic [HOP_W-1:0]   ccwi_hop_s;
    logic               cwi_eject_s;
    logic               ccwi_eject_s;
    logic               pei_ccw_s;
    logic [DATA_W-1:0]  cwi_fwd_s;
    logic [DATA_W-1:0]  ccwi_fwd_s;
    logic [N_PORTS-1:0] req_a_s;
    logic [N_PORTS-1:0] req_b_s;
    logic [N_PORTS-1:0] gnt_a_s;
    logic [N_PORTS-1:0] gnt_b_s;
    logic [N_PORTS-1:0] can_load_s;
    logic [N_PORTS-1:0] out_rdy_s;
    logic [N_PORTS-1:0] out_v_s;
    logic [DATA_W-1:0]  dat_a_s [N_PORTS];
    logic [DATA_W-1:0]  dat_b_s [N_PORTS];
    logic [DATA_W-1:0]  out_d_s [N_PORTS];

    assign cwi_hop_s    = cwi_d[HOP_M:HOP_L];
    assign ccwi_hop_s   = ccwi_d[HOP_M:HOP_L];
    assign cwi_eject_s  = (cwi_hop_s == {HOP_W{1'b0}});
    assign ccwi_eject_s = (ccwi_hop_s == {HOP_W{1'b0}});
    assign pei_ccw_s    = pei_d[DIR_B];

    // Forwarded ring packets leave with hop-1; hop is nonzero on this path, so no wrap.
    always_comb begin
        cwi_fwd_s  = cwi_d;
        ccwi_fwd_s = ccwi_d;
        cwi_fwd_s[HOP_M:HOP_L]  = cwi_hop_s - HOP_W'(1'b1);
        ccwi_fwd_s[HOP_M:HOP_L] = ccwi_hop_s - HOP_W'(1'b1);
    end

    // Side A is the ring input on cwo/ccwo and cwi on peo.
    assign req_a_s[CWI]  = cwi_v && !cwi_eject_s;
    assign req_b_s[CWI]  = pei_v && !pei_ccw_s;
    assign dat_a_s[CWI]  = cwi_fwd_s;
    assign dat_b_s[CWI]  = pei_d;
    assign req_a_s[CCWI] = ccwi_v && !ccwi_eject_s;
    assign req_b_s[CCWI] = pei_v && pei_ccw_s;
    assign dat_a_s[CCWI] = ccwi_fwd_s;
    assign dat_b_s[CCWI] = pei_d;
    assign req_a_s[PEI]  = cwi_v && cwi_eject_s;
    assign req_b_s[PEI]  = ccwi_v && ccwi_eject_s;
    assign dat_a_s[PEI]  = cwi_d;
    assign dat_b_s[PEI]  = ccwi_d;

    assign out_rdy_s[CWI]  = cwo_rdy;
    assign out_rdy_s[CCWI] = ccwo_rdy;
    assign out_rdy_s[PEI]  = peo_rdy;

    for (genvar o = 0; o < N_PORTS; o++) begin : g_out
        logic              v_q;
        logic              v_d;
        logic [DATA_W-1:0] d_q;
        logic [DATA_W-1:0] d_d;

        assign can_load_s[o] = !v_q || out_rdy_s[o];

        rte_arb2 u_arb (
`ifdef RTE_RR_EN
            .clk        (clk),
            .rst_n      (rst_n),
`endif
            .req_a_i    (req_a_s[o]),
            .req_b_i    (req_b_s[o]),
            .can_load_i (can_load_s[o]),
            .gnt_a_o    (gnt_a_s[o]),
            .gnt_b_o    (gnt_b_s[o])
        );

        // Output stage: load on grant, empty on handshake, otherwise hold.
        always_comb begin
            v_d = v_q;
            d_d = d_q;
            if (gnt_a_s[o]) begin
                v_d = 1'b1;
                d_d = dat_a_s[o];
            end else if (gnt_b_s[o]) begin
                v_d = 1'b1;
                d_d = dat_b_s[o];
            end else if (out_rdy_s[o]) begin
                v_d = 1'b0;
            end else begin
                v_d = v_q;
            end
        end

        // Output stage register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= {DATA_W{1'b0}};
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign out_v_s[o] = v_q;
        assign out_d_s[o] = d_q;
    end

    assign cwi_rdy  = gnt_a_s[CWI] | gnt_a_s[PEI];
    assign ccwi_rdy = gnt_a_s[CCWI] | gnt_b_s[PEI];
    assign pei_rdy  = gnt_b_s[CWI] | gnt_b_s[CCWI];

    assign cwo_v  = out_v_s[CWI];
    assign ccwo_v = out_v_s[CCWI];
    assign peo_v  = out_v_s[PEI];
    assign cwo_d  = out_d_s[CWI];
    assign ccwo_d = out_d_s[CCWI];
    assign peo_d  = out_d_s[PEI];

endmodule

// File: tb/tb_rte_switch.sv
// tb_rte_switch: directed scenarios for rte_switch with a routing scoreboard on all three outputs.
module tb_rte_switch;

    localparam int DW    = 64;
    localparam int HW    = 8;
    localparam int HOP_M = DW - 2;
    localparam int HOP_L = DW - 1 - HW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cwi_v = 1'b0, ccwi_v = 1'b0, pei_v = 1'b0;
    logic [DW-1:0] cwi_d = '0, ccwi_d = '0, pei_d = '0;
    logic          cwi_rdy, ccwi_rdy, pei_rdy;
    logic          cwo_v, ccwo_v, peo_v;
    logic [DW-1:0] cwo_d, ccwo_d, peo_d;
    logic          cwo_rdy = 1'b1, ccwo_rdy = 1'b1, peo_rdy = 1'b1;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] q_cw[$];
    logic [DW-1:0] q_ccw[$];
    logic [DW-1:0] q_pe[$];
    logic [DW-1:0] mon_e;

    rte_switch #(.DATA_W(DW), .HOP_W(HW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cwi_v(cwi_v), .ccwi_v(ccwi_v), .pei_v(pei_v),
        .cwi_d(cwi_d), .ccwi_d(ccwi_d), .pei_d(pei_d),
        .cwi_rdy(cwi_rdy), .ccwi_rdy(ccwi_rdy), .pei_rdy(pei_rdy),
        .cwo_v(cwo_v), .ccwo_v(ccwo_v), .peo_v(peo_v),
        .cwo_d(cwo_d), .ccwo_d(ccwo_d), .peo_d(peo_d),
        .cwo_rdy(cwo_rdy), .ccwo_rdy(ccwo_rdy), .peo_rdy(peo_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] mk(input logic dir, input logic [HW-1:0] hop,
                                          input logic [DW-HW-2:0] pay);
        return {dir, hop, pay};
    endfunction

    // Scoreboard: pop on output handshakes, push routed packets on input transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cwo_v && cwo_rdy) begin
                n_tests++;
                if (q_cw.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_cwo: got %h, required nothing (queue empty)", cwo_d);
                end else begin
                    mon_e = q_cw.pop_front();
                    if (cwo_d !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_cwo: got %h, required %h", cwo_d, mon_e);
                    end
                end
            end
            if (ccwo_v && ccwo_rdy) begin
                n_tests++;
                if (q_ccw.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_ccwo: got %h, required nothing (queue empty)", ccwo_d);
                end else begin
                    mon_e = q_ccw.pop_front();
                    if (ccwo_d !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_ccwo: got %h, required %h", ccwo_d, mon_e);
                    end
                end
            end
            if (peo_v && peo_rdy) begin
                n_tests++;
                if (q_pe.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_peo: got %h, required nothing (queue empty)", peo_d);
                end else begin
                    mon_e = q_pe.pop_front();
                    if (peo_d !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_peo: got %h, required %h", peo_d, mon_e);
                    end
                end
            end
            if (cwi_v && cwi_rdy) begin
                if (cwi_d[HOP_M:HOP_L] == 8'd0) begin
                    q_pe.push_back(cwi_d);
                end else begin
                    mon_e = cwi_d;
                    mon_e[HOP_M:HOP_L] = cwi_d[HOP_M:HOP_L] - 8'd1;
                    q_cw.push_back(mon_e);
                end
            end
            if (ccwi_v && ccwi_rdy) begin
                if (ccwi_d[HOP_M:HOP_L] == 8'd0) begin
                    q_pe.push_back(ccwi_d);
                end else begin
                    mon_e = ccwi_d;
                    mon_e[HOP_M:HOP_L] = ccwi_d[HOP_M:HOP_L] - 8'd1;
                    q_ccw.push_back(mon_e);
                end
            end
            if (pei_v && pei_rdy) begin
                if (pei_d[DW-1]) q_ccw.push_back(pei_d);
                else             q_cw.push_back(pei_d);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({cwo_v, ccwo_v, peo_v} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, required 000", {cwo_v, ccwo_v, peo_v});
        end
        n_tests++;
        if ({cwo_d, ccwo_d, peo_d} !== {(3*DW){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h, required all zero", cwo_d, ccwo_d, peo_d);
        end
        n_tests++;
        if ({cwi_rdy, ccwi_rdy, pei_rdy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_rdy: got %b, required 000", {cwi_rdy, ccwi_rdy, pei_rdy});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        cwi_v = 1'b1;
        cwi_d = mk(1'b0, 8'd3, 55'h12345);
        @(negedge clk);
        n_tests++;
        if (cwi_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_rdy: got %b, required 1", cwi_rdy);
        end
        @(posedge clk); #1;
        cwi_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cwo_v !== 1'b1 || cwo_d !== mk(1'b0, 8'd2, 55'h12345)) begin
            n_fail++;
            $display("FAIL fwd_out: got v=%b d=%h, required v=1 d=%h", cwo_v, cwo_d,
                     mk(1'b0, 8'd2, 55'h12345));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_eject();
        logic [DW-1:0] p;
        p = mk(1'b0, 8'd0, 55'h0BEEF);
        ccwi_v = 1'b1;
        ccwi_d = p;
        @(negedge clk);
        n_tests++;
        if (ccwi_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL eject_rdy: got %b, required 1", ccwi_rdy);
        end
        @(posedge clk); #1;
        ccwi_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if (peo_v !== 1'b1 || peo_d !== p || ccwo_v !== 1'b0) begin
            n_fail++;
            $display("FAIL eject_out: got peo_v=%b peo_d=%h ccwo_v=%b, required 1 %h 0",
                     peo_v, peo_d, ccwo_v, p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic exp_pe, took_cw, took_pe;
        cwi_v = 1'b1;
        cwi_d = mk(1'b0, 8'd5, 55'd100);
        pei_v = 1'b1;
        pei_d = mk(1'b0, 8'd7, 55'd200);
        for (int i = 0; i < 4; i++) begin
`ifdef RTE_RR_EN
            exp_pe = i[0];
`else
            exp_pe = 1'b0;
`endif
            @(negedge clk);
            took_cw = cwi_rdy;
            took_pe = pei_rdy;
            n_tests++;
            if ({cwi_rdy, pei_rdy} !== {~exp_pe, exp_pe}) begin
                n_fail++;
                $display("FAIL contend_gnt[%0d]: got cwi_rdy,pei_rdy=%b%b, required %b%b",
                         i, cwi_rdy, pei_rdy, ~exp_pe, exp_pe);
            end
            @(posedge clk); #1;
            if (took_cw) cwi_d = mk(1'b0, 8'd5, 55'(101 + i));
            if (took_pe) pei_d = mk(1'b0, 8'd7, 55'(201 + i));
        end
        cwi_v = 1'b0;
        pei_v = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_peo_contention();
        logic [DW-1:0] pa, pb;
        pa = mk(1'b0, 8'd0, 55'h0A1);
        pb = mk(1'b1, 8'd0, 55'h0B2);
        cwi_v = 1'b1;  cwi_d = pa;
        ccwi_v = 1'b1; ccwi_d = pb;
        @(negedge clk);
        n_tests++;
        if ({cwi_rdy, ccwi_rdy} !== 2'b10) begin
            n_fail++;
            $display("FAIL peo_first: got cwi_rdy,ccwi_rdy=%b%b, required 10", cwi_rdy, ccwi_rdy);
        end
        @(posedge clk); #1;
        cwi_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ccwi_rdy !== 1'b1 || peo_v !== 1'b1 || peo_d !== pa) begin
            n_fail++;
            $display("FAIL peo_second: got ccwi_rdy=%b peo_v=%b peo_d=%h, required 1 1 %h",
                     ccwi_rdy, peo_v, peo_d, pa);
        end
        @(posedge clk); #1;
        ccwi_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if (peo_v !== 1'b1 || peo_d !== pb) begin
            n_fail++;
            $display("FAIL peo_third: got peo_v=%b peo_d=%h, required 1 %h", peo_v, peo_d, pb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        cwo_rdy = 1'b0;
        cwi_v = 1'b1;
        cwi_d = mk(1'b0, 8'd4, 55'h0C3);
        @(negedge clk);
        n_tests++;
        if (cwi_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_fill: got cwi_rdy=%b, required 1", cwi_rdy);
        end
        @(posedge clk); #1;
        cwi_d = mk(1'b0, 8'd6, 55'h0D4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (cwo_v !== 1'b1 || cwo_d !== mk(1'b0, 8'd3, 55'h0C3) || cwi_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h cwi_rdy=%b, required 1 %h 0",
                         i, cwo_v, cwo_d, cwi_rdy, mk(1'b0, 8'd3, 55'h0C3));
            end
            @(posedge clk); #1;
        end
        cwo_rdy = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cwi_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got cwi_rdy=%b, required 1", cwi_rdy);
        end
        @(posedge clk); #1;
        cwi_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cwo_v !== 1'b1 || cwo_d !== mk(1'b0, 8'd5, 55'h0D4)) begin
            n_fail++;
            $display("FAIL stall_next: got v=%b d=%h, required 1 %h", cwo_v, cwo_d,
                     mk(1'b0, 8'd5, 55'h0D4));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] p;
        cwo_rdy = 1'b0; ccwo_rdy = 1'b0; peo_rdy = 1'b0;
        cwi_v = 1'b1;  cwi_d  = mk(1'b0, 8'd2, 55'h0E5);
        ccwi_v = 1'b1; ccwi_d = mk(1'b0, 8'd0, 55'h0F6);
        pei_v = 1'b1;  pei_d  = mk(1'b1, 8'd3, 55'h0A7);
        @(negedge clk);
        n_tests++;
        if ({cwi_rdy, ccwi_rdy, pei_rdy} !== 3'b111) begin
            n_fail++;
            $display("FAIL concurrent_rdy: got %b, required 111", {cwi_rdy, ccwi_rdy, pei_rdy});
        end
        @(posedge clk); #1;
        cwi_v = 1'b0; ccwi_v = 1'b0; pei_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({cwo_v, ccwo_v, peo_v} !== 3'b111) begin
            n_fail++;
            $display("FAIL concurrent_out: got %b, required 111", {cwo_v, ccwo_v, peo_v});
        end
        #2;
        rst_n = 1'b0;
        q_cw.delete();
        q_ccw.delete();
        q_pe.delete();
        #1;
        n_tests++;
        if ({cwo_v, ccwo_v, peo_v} !== 3'b000 || {cwo_d, ccwo_d, peo_d} !== {(3*DW){1'b0}}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b d=%h %h %h, required 000 and zero data",
                     {cwo_v, ccwo_v, peo_v}, cwo_d, ccwo_d, peo_d);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cwo_rdy = 1'b1; ccwo_rdy = 1'b1; peo_rdy = 1'b1;
        p = mk(1'b1, 8'd9, 55'h01234);
        pei_v = 1'b1;
        pei_d = p;
        @(negedge clk);
        n_tests++;
        if (pei_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_rdy: got %b, required 1", pei_rdy);
        end
        @(posedge clk); #1;
        pei_v = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ccwo_v !== 1'b1 || ccwo_d !== p) begin
            n_fail++;
            $display("FAIL post_reset_out: got v=%b d=%h, required 1 %h", ccwo_v, ccwo_d, p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        cwo_rdy = 1'b1; ccwo_rdy = 1'b1; peo_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (q_cw.size() + q_ccw.size() + q_pe.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d packets outstanding, required 0",
                     q_cw.size() + q_ccw.size() + q_pe.size());
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_eject();
        test_contention();
        test_peo_contention();
        test_stall();
        test_reset_mid();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
